// File: rtl/c17_pkg.sv
// Shared widths, bit positions and a reference evaluator for the c17 NAND netlist.
package c17_pkg;

  localparam int C17_IN_W  = 5;
  localparam int C17_OUT_W = 2;

  localparam int IDX_NX1 = 0;
  localparam int IDX_NX2 = 1;
  localparam int IDX_NX3 = 2;
  localparam int IDX_NX6 = 3;
  localparam int IDX_NX7 = 4;

  localparam int IDX_NX22 = 0;
  localparam int IDX_NX23 = 1;

  typedef logic [C17_IN_W-1:0]  c17_in_t;
  typedef logic [C17_OUT_W-1:0] c17_out_t;

  function automatic c17_out_t c17_eval(input c17_in_t x);
    logic     n0;
    logic     n1;
    logic     n2;
    logic     n3;
    c17_out_t y;
    n1 = ~(x[IDX_NX3] & x[IDX_NX6]);
    n0 = ~(x[IDX_NX1] & x[IDX_NX3]);
    n2 = ~(x[IDX_NX7] & n1);
    n3 = ~(x[IDX_NX2] & n1);
    y[IDX_NX22] = ~(n0 & n3);
    y[IDX_NX23] = ~(n3 & n2);
    return y;
  endfunction

endpackage

// File: rtl/c17_lane.sv
// One c17 lane: three NAND levels with optional data registers between them.
// Optional C17_PARITY_EN carries the XOR of the lane inputs alongside the data.
module c17_lane
  import c17_pkg::*;
#(
  parameter int PIPE_STAGES = 1
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIPE_STAGES:0] i_ld,
  input  logic [C17_IN_W-1:0]  i_in,
  output logic [C17_OUT_W-1:0] o_out
`ifdef C17_PARITY_EN
  ,
  output logic                 o_par
`endif
);

  // Level-1 bundle {nx7, nx2, net_1, net_0}; level-2 bundle {net_0, net_3, net_2}.
  logic [3:0]           w_l1;
  logic [3:0]           w_l1_q;
  logic [2:0]           w_l2;
  logic [2:0]           w_l2_q;
  logic [C17_OUT_W-1:0] w_l3;
  logic [C17_OUT_W-1:0] r_out;
`ifdef C17_PARITY_EN
  logic w_p0;
  logic w_p1;
  logic w_p2;
  logic r_par;
  assign w_p0 = ^i_in;
`endif

  assign w_l1 = {i_in[IDX_NX7], i_in[IDX_NX2],
                 ~(i_in[IDX_NX3] & i_in[IDX_NX6]),
                 ~(i_in[IDX_NX1] & i_in[IDX_NX3])};

  if (PIPE_STAGES >= 1) begin : g_s1
    logic [3:0] r_l1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_l1 <= '0;
      end else if (i_ld[0]) begin
        r_l1 <= w_l1;
      end
    end
    assign w_l1_q = r_l1;
`ifdef C17_PARITY_EN
    logic r_p1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_p1 <= 1'b0;
      end else if (i_ld[0]) begin
        r_p1 <= w_p0;
      end
    end
    assign w_p1 = r_p1;
`endif
  end else begin : g_s1_bypass
    assign w_l1_q = w_l1;
`ifdef C17_PARITY_EN
    assign w_p1 = w_p0;
`endif
  end

  assign w_l2 = {w_l1_q[0], ~(w_l1_q[2] & w_l1_q[1]), ~(w_l1_q[3] & w_l1_q[1])};

  if (PIPE_STAGES >= 2) begin : g_s2
    logic [2:0] r_l2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_l2 <= '0;
      end else if (i_ld[1]) begin
        r_l2 <= w_l2;
      end
    end
    assign w_l2_q = r_l2;
`ifdef C17_PARITY_EN
    logic r_p2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_p2 <= 1'b0;
      end else if (i_ld[1]) begin
        r_p2 <= w_p1;
      end
    end
    assign w_p2 = r_p2;
`endif
  end else begin : g_s2_bypass
    assign w_l2_q = w_l2;
`ifdef C17_PARITY_EN
    assign w_p2 = w_p1;
`endif
  end

  always_comb begin
    w_l3           = '0;
    w_l3[IDX_NX22] = ~(w_l2_q[2] & w_l2_q[1]);
    w_l3[IDX_NX23] = ~(w_l2_q[1] & w_l2_q[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (i_ld[PIPE_STAGES]) begin
      r_out <= w_l3;
    end
  end
  assign o_out = r_out;

`ifdef C17_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (i_ld[PIPE_STAGES]) begin
      r_par <= w_p2;
    end
  end
  assign o_par = r_par;
`endif

endmodule

// File: rtl/c17_pipe_array.sv
// NCH pipelined c17 lanes on one valid/ready stream with saturating per-output toggle counters.
// Optional C17_PARITY_EN adds out_par, the per-lane input XOR aligned with out_data.
module c17_pipe_array
  import c17_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [C17_IN_W*NCH-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [C17_OUT_W*NCH-1:0]   out_data,
  input  logic                       cnt_clr,
  input  logic [$clog2(2*NCH)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]           cnt_value
`ifdef C17_PARITY_EN
  ,
  output logic [NCH-1:0]             out_par
`endif
);

  localparam int NST  = PIPE_STAGES + 1;
  localparam int NCNT = C17_OUT_W * NCH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: a beat moves on a rising edge when in_valid && in_ready (input side)
  // or out_valid && out_ready (output side); a stage may load while it drains.
  logic [NST-1:0] r_v;
  logic [NST-1:0] w_en;
  logic [NST-1:0] w_vin;
  logic [NST-1:0] w_ld;

  always_comb begin
    w_en  = '0;
    w_vin = '0;
    w_ld  = '0;
    w_en[NST-1] = ~r_v[NST-1] | out_ready;
    for (int i = NST - 2; i >= 0; i--) begin
      w_en[i] = ~r_v[i] | w_en[i+1];
    end
    w_vin[0] = in_valid;
    for (int i = 1; i < NST; i++) begin
      w_vin[i] = r_v[i-1];
    end
    w_ld = w_en & w_vin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < NST; i++) begin
        if (w_en[i]) begin
          r_v[i] <= w_vin[i];
        end
      end
    end
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_v[NST-1];

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    c17_lane #(
      .PIPE_STAGES (PIPE_STAGES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_ld  (w_ld),
      .i_in  (in_data[C17_IN_W*k +: C17_IN_W]),
      .o_out (out_data[C17_OUT_W*k +: C17_OUT_W])
`ifdef C17_PARITY_EN
      ,
      .o_par (out_par[k])
`endif
    );
  end

  // Toggle activity is measured between consecutive transferred beats only.
  logic [CNT_W-1:0] r_cnt [NCNT];
  logic [NCNT-1:0]  r_shadow;
  logic             w_fire;
  logic [NCNT-1:0]  w_tog;

  assign w_fire = out_valid & out_ready;
  assign w_tog  = (out_data ^ r_shadow) & {NCNT{w_fire}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      for (int j = 0; j < NCNT; j++) begin
        r_cnt[j] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_shadow <= out_data;
      end
      for (int j = 0; j < NCNT; j++) begin
        if (cnt_clr) begin
          r_cnt[j] <= '0;
        end else if (w_tog[j] && (r_cnt[j] != CNT_MAX)) begin
          r_cnt[j] <= r_cnt[j] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int j = 0; j < NCNT; j++) begin
      if (int'(cnt_sel) == j) begin
        cnt_value = r_cnt[j];
      end
    end
  end

endmodule
